// File: rtl/cacheline_burst_adaptor.sv
// rtl/cacheline_burst_adaptor.sv - cache line to 4-beat memory burst adaptor
module cacheline_burst_adaptor #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [ADDR_WIDTH-1:0] line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [ADDR_WIDTH-1:0] burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W       = $clog2(BEATS);
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    logic [LINE_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] aligned_addr;
    logic                  last_beat;
    logic                  line_offset_unused;

    // Byte offset within the line never reaches memory.
    assign aligned_addr       = {line_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign line_offset_unused = ^line_address[OFFSET_BITS-1:0];
    assign last_beat          = burst_resp && (cnt_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (line_read) begin
                    addr_d  = aligned_addr;
                    cnt_d   = '0;
                    buf_d   = '0;
                    state_d = READ;
                end else if (line_write) begin
                    addr_d  = aligned_addr;
                    wdata_d = line_wdata;
                    cnt_d   = '0;
                    state_d = WRITE;
                end
            end
            READ: begin
                if (burst_resp) begin
                    buf_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    // Publish the completed line so it is already valid during DONE.
                    if (last_beat) begin
                        rdata_d = buf_d;
                        state_d = DONE;
                    end
                end
            end
            WRITE: begin
                if (burst_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign burst_read    = (state_q == READ);
    assign burst_write   = (state_q == WRITE);
    assign burst_address = addr_q;
    assign burst_wdata   = (state_q == WRITE) ? wdata_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] : '0;
    assign line_resp     = (state_q == DONE);
    assign line_rdata    = rdata_q;

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb/tb_cacheline_burst_adaptor.sv - scoreboard bench for cacheline_burst_adaptor
module tb_cacheline_burst_adaptor;
    logic         clk = 1'b0;
    logic         rst;
    logic         line_read, line_write;
    logic [31:0]  line_address;
    logic [255:0] line_wdata, line_rdata;
    logic         line_resp, burst_read, burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata, burst_rdata;
    logic         burst_resp;

    always #5 clk = ~clk;

    cacheline_burst_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .line_read    (line_read),
        .line_write   (line_write),
        .line_address (line_address),
        .line_wdata   (line_wdata),
        .line_rdata   (line_rdata),
        .line_resp    (line_resp),
        .burst_read   (burst_read),
        .burst_write  (burst_write),
        .burst_address(burst_address),
        .burst_wdata  (burst_wdata),
        .burst_rdata  (burst_rdata),
        .burst_resp   (burst_resp)
    );

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [63:0] wdata;
    } beat_t;

    typedef struct {
        int           cyc;
        logic [255:0] data;
    } line_t;

    beat_t        exp_beat_q[$];
    line_t        exp_line_q[$];
    int           gap_q[$];
    logic [63:0]  rd_beat_q[$];
    int           checks = 0;
    int           passed = 0;
    int           cyc = 0;
    int           resp_seen = 0;
    logic [255:0] last_rd = '0;

    function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: each beat is preceded by its queued number of idle cycles.
    int wait_cnt = 0;
    bit cur_rd = 1'b0;
    bit took;
    always @(posedge clk) begin
        took = burst_resp && rst;
        #1;
        if (took) begin
            if (gap_q.size() > 0) void'(gap_q.pop_front());
            if (cur_rd && rd_beat_q.size() > 0) void'(rd_beat_q.pop_front());
            wait_cnt = 0;
        end
        burst_resp  = 1'b0;
        burst_rdata = '0;
        if (rst && (burst_read || burst_write) && gap_q.size() > 0) begin
            if (wait_cnt < gap_q[0]) begin
                wait_cnt++;
            end else begin
                burst_resp = 1'b1;
                cur_rd     = burst_read;
                if (burst_read && rd_beat_q.size() > 0) burst_rdata = rd_beat_q[0];
            end
        end
        if (!rst) wait_cnt = 0;
    end

    beat_t mon_beat;
    line_t mon_line;
    always @(negedge clk) begin
        if (rst && burst_resp && (burst_read || burst_write)) begin
            check("beat_expected", exp_beat_q.size() != 0, 1);
            if (exp_beat_q.size() != 0) begin
                mon_beat = exp_beat_q.pop_front();
                check("beat_is_write", burst_write, mon_beat.is_write);
                check("beat_is_read", burst_read, !mon_beat.is_write);
                check("burst_address", burst_address, mon_beat.addr);
                if (mon_beat.is_write) check("burst_wdata", burst_wdata, mon_beat.wdata);
            end
        end
        if (line_resp) begin
            resp_seen++;
            check("line_resp_expected", exp_line_q.size() != 0, 1);
            if (exp_line_q.size() != 0) begin
                mon_line = exp_line_q.pop_front();
                check("line_rdata", line_rdata, mon_line.data);
                check("line_resp_cycle", cyc, mon_line.cyc);
            end
        end
    end

    task automatic start_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                              input logic [255:0] data, input int g0, input int g1,
                              input int g2, input int g3, input int extra, input bit expect_line);
        int    gaps[4];
        beat_t e;
        line_t l;
        gaps = '{g0, g1, g2, g3};
        for (int i = 0; i < 4; i++) begin
            gap_q.push_back(gaps[i]);
            rd_beat_q.push_back(data[i*64 +: 64]);
            e.is_write = 1'b0;
            e.addr     = exp_addr;
            e.wdata    = '0;
            exp_beat_q.push_back(e);
        end
        if (expect_line) begin
            l.cyc  = cyc + 5 + g0 + g1 + g2 + g3 + extra;
            l.data = data;
            exp_line_q.push_back(l);
            last_rd = data;
        end
        line_address = addr;
        line_read    = 1'b1;
    endtask

    task automatic start_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                               input logic [255:0] data, input int g0, input int g1,
                               input int g2, input int g3, input int extra);
        int    gaps[4];
        beat_t e;
        line_t l;
        gaps = '{g0, g1, g2, g3};
        for (int i = 0; i < 4; i++) begin
            gap_q.push_back(gaps[i]);
            e.is_write = 1'b1;
            e.addr     = exp_addr;
            e.wdata    = data[i*64 +: 64];
            exp_beat_q.push_back(e);
        end
        l.cyc  = cyc + 5 + g0 + g1 + g2 + g3 + extra;
        l.data = last_rd;
        exp_line_q.push_back(l);
        line_address = addr;
        line_wdata   = data;
        line_write   = 1'b1;
    endtask

    task automatic wait_resp(input int n);
        int t = 0;
        while (resp_seen < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (resp_seen < n) check("line_resp_timeout", resp_seen, n);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_line_resp"}, line_resp, 0);
        check({tag, "_burst_read"}, burst_read, 0);
        check({tag, "_burst_write"}, burst_write, 0);
        check({tag, "_burst_address"}, burst_address, 0);
        check({tag, "_burst_wdata"}, burst_wdata, 0);
        check({tag, "_line_rdata"}, line_rdata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    localparam logic [255:0] D1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] WD = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                   64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    localparam logic [255:0] D3 = {64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202,
                                   64'h0101_0101_0101_0101, 64'h0000_0000_0000_00F0};
    localparam logic [255:0] W3 = {64'hF3F3_F3F3_0000_0000, 64'hF2F2_F2F2_0000_0000,
                                   64'hF1F1_F1F1_0000_0000, 64'hF0F0_F0F0_0000_0000};
    localparam logic [255:0] D5 = {64'h5555_0000_0000_0004, 64'h5555_0000_0000_0003,
                                   64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
    localparam logic [255:0] D6 = {64'h6666_DEAD_BEEF_0004, 64'h6666_DEAD_BEEF_0003,
                                   64'h6666_DEAD_BEEF_0002, 64'h6666_DEAD_BEEF_0001};
    localparam logic [255:0] D7 = {64'h7777_0123_4567_89AB, 64'h7777_1111_2222_3333,
                                   64'h7777_4444_5555_6666, 64'h7777_7777_8888_9999};
    localparam logic [255:0] D8 = {64'h8888_0000_0000_0008, 64'h8888_0000_0000_0007,
                                   64'h8888_0000_0000_0006, 64'h8888_0000_0000_0005};

    initial begin
        rst          = 1'b1;
        line_read    = 1'b0;
        line_write   = 1'b0;
        line_address = '0;
        line_wdata   = '0;
        burst_resp   = 1'b0;
        burst_rdata  = '0;
        #2 rst = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Read, beats on consecutive cycles.
        start_read(32'h0000_1234, 32'h0000_1220, D1, 0, 0, 0, 0, 0, 1'b1);
        wait_resp(1);
        line_read = 1'b0;
        @(posedge clk); #1;

        // Same read with gaps: beat, 2 idle, beat, 1 idle, beat, beat.
        start_read(32'h0000_1234, 32'h0000_1220, D1, 0, 2, 1, 0, 0, 1'b1);
        wait_resp(2);
        line_read = 1'b0;
        @(posedge clk); #1;

        // Write: beats go out low 64 bits first; line_rdata keeps the last read line.
        start_write(32'h8000_0040, 32'h8000_0040, WD, 0, 0, 0, 0, 0);
        wait_resp(3);
        line_write = 1'b0;
        @(posedge clk); #1;

        // Read and write together: read first, write sampled in the next IDLE cycle.
        start_read(32'h0000_0310, 32'h0000_0300, D3, 0, 0, 0, 0, 0, 1'b1);
        start_write(32'h0000_0310, 32'h0000_0300, W3, 0, 1, 0, 0, 6);
        wait_resp(4);
        line_read = 1'b0;
        wait_resp(5);
        line_write = 1'b0;
        @(posedge clk); #1;

        // Reset after two beats of a read.
        begin
            int t = 0;
            start_read(32'h0000_0500, 32'h0000_0500, D5, 0, 0, 100, 0, 0, 1'b0);
            while (rd_beat_q.size() > 2 && t < 50) begin
                @(posedge clk);
                t++;
            end
            check("abort_beats_taken", rd_beat_q.size(), 2);
            @(negedge clk);
            rst       = 1'b0;
            line_read = 1'b0;
            #1 check_idle_outputs("abort");
            gap_q.delete();
            rd_beat_q.delete();
            check("abort_pending_beats", exp_beat_q.size(), 2);
            exp_beat_q.delete();
            last_rd = '0;
            repeat (3) @(negedge clk);
            check_idle_outputs("abort_held");
            rst = 1'b1;
            @(posedge clk); #1;
        end

        start_read(32'h0000_061F, 32'h0000_0600, D6, 0, 0, 0, 0, 0, 1'b1);
        wait_resp(6);
        line_read = 1'b0;
        @(posedge clk); #1;

        // Back-to-back reads: request stays high with a new address.
        start_read(32'h0000_1000, 32'h0000_1000, D7, 0, 0, 0, 0, 0, 1'b1);
        wait_resp(7);
        start_read(32'h0000_2000, 32'h0000_2000, D8, 0, 0, 0, 0, 0, 1'b1);
        wait_resp(8);
        line_read = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        check("final_line_queue_empty", exp_line_q.size(), 0);
        check("final_beat_queue_empty", exp_beat_q.size(), 0);
        check("final_resp_count", resp_seen, 8);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
